// File: rtl/fwrisc_dmem_responder.sv
// fwrisc data-bus responder: word-addressed SRAM with programmable wait states.
// Define FWRISC_DMEM_MMIO_EN to map the console/halt MMIO window at MMIO_BASE.
module fwrisc_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic        dwrite,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        addr_err,
  output logic        proto_err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        halt,
  output logic [31:0] halt_code
);

  // state | meaning
  // IDLE  | waiting for dvalid; only state in which a request is sampled
  // WAIT  | counting wait states; read data captured on the last one
  // ACK   | dready (gated by dvalid) for one cycle; write commits at its end
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam int AW = $clog2(DEPTH_WORDS * 4);

  state_t        state;
  logic [3:0]    cnt;
  logic [31:2]   req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstb;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:2]   rd_addr;
  logic [31:0]   rd_data;
  logic          commit;
  logic          unused_bits;

  function automatic logic hit_sram(input logic [31:2] a);
    return a[31:AW] == BASE_ADDR[31:AW];
  endfunction

  function automatic logic hit_mmio(input logic [31:2] a);
`ifdef FWRISC_DMEM_MMIO_EN
    return a[31:3] == MMIO_BASE[31:3];
`else
    return 1'b0 & a[2];
`endif
  endfunction

  // In IDLE with zero wait states the read is served straight from the bus.
  assign rd_addr = (state == IDLE) ? daddr[31:2] : req_addr;

  // A completed ACK (dvalid still high) is what commits writes and side effects.
  assign commit   = (state == ACK) && dvalid;
  assign dready   = commit;
  assign addr_err = commit && !hit_sram(req_addr) && !hit_mmio(req_addr);

`ifdef FWRISC_DMEM_MMIO_EN
  logic        halt_q;
  logic [31:0] halt_code_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h0;
    end else begin
      tx_valid_q <= 1'b0;
      if (commit && req_write && hit_mmio(req_addr)) begin
        if (!req_addr[2] && req_wstb[0]) begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= req_wdata[7:0];
        end
        if (req_addr[2] && !halt_q) begin
          halt_q      <= 1'b1;
          halt_code_q <= req_wdata;
        end
      end
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign halt        = halt_q;
  assign halt_code   = halt_code_q;
  assign unused_bits = ^daddr[1:0];
`else
  assign tx_valid    = 1'b0;
  assign tx_data     = 8'h0;
  assign halt        = 1'b0;
  assign halt_code   = 32'h0;
  assign unused_bits = ^{daddr[1:0], MMIO_BASE};
`endif

  always_comb begin
    rd_data = 32'h0;
    if (hit_sram(rd_addr))
      rd_data = mem[rd_addr[AW-1:2]];
`ifdef FWRISC_DMEM_MMIO_EN
    else if (hit_mmio(rd_addr))
      rd_data = rd_addr[2] ? halt_code_q : {31'b0, halt_q};
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset && commit && req_write && hit_sram(req_addr)) begin
      for (int b = 0; b < 4; b++)
        if (req_wstb[b])
          mem[req_addr[AW-1:2]][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_addr  <= '0;
      req_write <= 1'b0;
      req_wdata <= 32'h0;
      req_wstb  <= 4'h0;
      drdata    <= 32'h0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dvalid) begin
            req_addr  <= daddr[31:2];
            req_write <= dwrite;
            req_wdata <= dwdata;
            req_wstb  <= dwstb;
            cnt       <= WAIT_STATES[3:0];
            if (WAIT_STATES == 0) begin
              state <= ACK;
              if (!dwrite) drdata <= rd_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!dvalid) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (cnt == 4'd1) begin
            state <= ACK;
            if (!req_write) drdata <= rd_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          if (!dvalid) proto_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_dmem_responder.sv
// Scoreboard bench: dut0 has no wait states, dut1 has three.
// MMIO checks follow FWRISC_DMEM_MMIO_EN the same way the RTL does.
module tb_fwrisc_dmem_responder;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_s   [2];
  logic        dvalid_s  [2];
  logic [31:0] daddr_s   [2];
  logic        dwrite_s  [2];
  logic [31:0] dwdata_s  [2];
  logic [3:0]  dwstb_s   [2];
  logic [31:0] drdata_s  [2];
  logic        dready_s  [2];
  logic        addr_err_s[2];
  logic        proto_s   [2];
  logic        txv_s     [2];
  logic [7:0]  txd_s     [2];
  logic        halt_s    [2];
  logic [31:0] hcode_s   [2];

  exp_t q0[$];
  exp_t q1[$];
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fwrisc_dmem_responder #(.WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset_s[0]), .dvalid(dvalid_s[0]), .daddr(daddr_s[0]),
    .dwrite(dwrite_s[0]), .dwdata(dwdata_s[0]), .dwstb(dwstb_s[0]), .drdata(drdata_s[0]),
    .dready(dready_s[0]), .addr_err(addr_err_s[0]), .proto_err(proto_s[0]),
    .tx_valid(txv_s[0]), .tx_data(txd_s[0]), .halt(halt_s[0]), .halt_code(hcode_s[0]));

  fwrisc_dmem_responder #(.WAIT_STATES(3)) dut1 (
    .clock(clock), .reset(reset_s[1]), .dvalid(dvalid_s[1]), .daddr(daddr_s[1]),
    .dwrite(dwrite_s[1]), .dwdata(dwdata_s[1]), .dwstb(dwstb_s[1]), .drdata(drdata_s[1]),
    .dready(dready_s[1]), .addr_err(addr_err_s[1]), .proto_err(proto_s[1]),
    .tx_valid(txv_s[1]), .tx_data(txd_s[1]), .halt(halt_s[1]), .halt_code(hcode_s[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic mon(input int w, input exp_t e);
    checks++;
    if (addr_err_s[w] !== e.err || (e.chk_data && drdata_s[w] !== e.data)) begin
      failures++;
      $display("FAIL resp%0d: got data=%h err=%b expected data=%h err=%b",
               w, drdata_s[w], addr_err_s[w], e.data, e.err);
    end
  endtask

  // Monitors: pop one expectation per dready pulse.
  always @(negedge clock) begin
    if (dready_s[0]) begin
      if (q0.size() == 0) begin
        failures++; checks++;
        $display("FAIL unexpected_dready0: got 1 expected 0");
      end else mon(0, q0.pop_front());
    end
  end

  always @(negedge clock) begin
    if (dready_s[1]) begin
      if (q1.size() == 0) begin
        failures++; checks++;
        $display("FAIL unexpected_dready1: got 1 expected 0");
      end else mon(1, q1.pop_front());
    end
  end

  task automatic req(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic chk, input logic [31:0] exp_d,
                     input logic exp_e, input int exp_lat, input logic hold);
    exp_t e;
    int n;
    e.chk_data = chk; e.data = exp_d; e.err = exp_e;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
    dvalid_s[w] = 1'b1; dwrite_s[w] = wr; daddr_s[w] = a; dwdata_s[w] = d; dwstb_s[w] = s;
    n = 0;
    do begin
      @(posedge clock); n++; #1;
    end while (!dready_s[w] && n < 20);
    check($sformatf("latency%0d@%h", w, a), n, dready_s[w] ? exp_lat : -1);
    @(posedge clock); #1;
    if (!hold) dvalid_s[w] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      reset_s[w] = 1'b1; dvalid_s[w] = 1'b0; daddr_s[w] = 32'h0;
      dwrite_s[w] = 1'b0; dwdata_s[w] = 32'h0; dwstb_s[w] = 4'h0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset_s[0] = 1'b0; reset_s[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_drdata%0d", w), drdata_s[w], 32'h0);
      check($sformatf("rst_flags%0d", w),
            {dready_s[w], addr_err_s[w], proto_s[w], txv_s[w], halt_s[w]}, 32'h0);
      check($sformatf("rst_mmio%0d", w), {txd_s[w], hcode_s[w][23:0]}, 32'h0);
    end

    // Zero wait states: write then read.
    req(0, 1, 32'h10, 32'h11223344, 4'hF, 0, 0, 0, 1, 0);
    req(0, 0, 32'h10, 0, 4'h0, 1, 32'h11223344, 0, 1, 0);
    // Byte lanes, and a zero-strobe write that changes nothing.
    req(0, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1, 0);
    req(0, 1, 32'h20, 32'h0000AB00, 4'b0010, 0, 0, 0, 1, 0);
    req(0, 0, 32'h20, 0, 4'h0, 1, 32'hFFFFABFF, 0, 1, 0);
    req(0, 1, 32'h20, 32'h00000000, 4'h0, 0, 0, 0, 1, 0);
    req(0, 0, 32'h22, 0, 4'h0, 1, 32'hFFFFABFF, 0, 1, 0);
    // Unmapped: first address past the SRAM.
    req(0, 1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 1, 0);
    req(0, 0, 32'h1000, 0, 4'h0, 1, 32'h0, 1, 1, 0);
    req(0, 1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, 0, 1, 1, 0);
    req(0, 0, 32'h0, 0, 4'h0, 1, 32'hA5A5A5A5, 0, 1, 0);
    req(0, 0, 32'h3FC, 0, 4'h0, 0, 0, 0, 1, 0);

`ifdef FWRISC_DMEM_MMIO_EN
    req(0, 1, 32'h80000000, 32'h00000041, 4'h1, 0, 0, 0, 1, 0);
    check("tx_valid_pulse", txv_s[0], 1);
    check("tx_data", txd_s[0], 32'h41);
    @(posedge clock); #1;
    check("tx_valid_end", txv_s[0], 0);
    req(0, 1, 32'h80000004, 32'h00000001, 4'hF, 0, 0, 0, 1, 0);
    check("halt", halt_s[0], 1);
    check("halt_code", hcode_s[0], 32'h1);
    req(0, 1, 32'h80000004, 32'h00000077, 4'hF, 0, 0, 0, 1, 0);
    check("halt_code_kept", hcode_s[0], 32'h1);
    req(0, 0, 32'h80000000, 0, 4'h0, 1, 32'h1, 0, 1, 0);
    req(0, 0, 32'h80000004, 0, 4'h0, 1, 32'h1, 0, 1, 0);
`else
    req(0, 1, 32'h80000000, 32'h00000041, 4'h1, 0, 0, 1, 1, 0);
    check("tx_valid_off", txv_s[0], 0);
    req(0, 1, 32'h80000004, 32'h00000001, 4'hF, 0, 0, 1, 1, 0);
    check("halt_off", {halt_s[0], hcode_s[0][30:0]}, 0);
`endif

    // Three wait states, back-to-back with dvalid held.
    req(1, 1, 32'h40, 32'h12345678, 4'hF, 0, 0, 0, 4, 1);
    req(1, 0, 32'h40, 0, 4'h0, 1, 32'h12345678, 0, 4, 0);

    // Abort in WAIT: no dready, sticky proto_err.
    dvalid_s[1] = 1'b1; dwrite_s[1] = 1'b0; daddr_s[1] = 32'h40;
    @(posedge clock); #1;
    dvalid_s[1] = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("proto_err_set", proto_s[1], 1);
    req(1, 0, 32'h40, 0, 4'h0, 1, 32'h12345678, 0, 4, 0);
    check("proto_err_sticky", proto_s[1], 1);

    // Reset during a write's WAIT discards the write.
    dvalid_s[1] = 1'b1; dwrite_s[1] = 1'b1; daddr_s[1] = 32'h40;
    dwdata_s[1] = 32'hDEADBEEF; dwstb_s[1] = 4'hF;
    @(posedge clock); #1;
    reset_s[1] = 1'b1; dvalid_s[1] = 1'b0;
    @(posedge clock); #1;
    reset_s[1] = 1'b0;
    check("proto_err_cleared", proto_s[1], 0);
    req(1, 0, 32'h40, 0, 4'h0, 1, 32'h12345678, 0, 4, 0);

    repeat (3) @(posedge clock);
    #1;
    check("queue0_empty", q0.size(), 0);
    check("queue1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
